// File: rtl/speck_decrypt_core.sv
// SPECK128/128 decryption core: expands the round keys one step per cycle, then
// applies one inverse round per cycle, pulsing finished when the plaintext is ready.
module speck_decrypt_core #(
    parameter int unsigned NR_ROUNDS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         signal_start,
    input  logic [127:0] key,
    input  logic [127:0] ciphertext,
    output logic [127:0] plaintext,
    output logic         finished,
    output logic [3:0]   state_response
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] EXPAND  = 4'd1;
    localparam logic [3:0] DECRYPT = 4'd2;
    localparam logic [3:0] DONE    = 4'd3;

    localparam logic [4:0] LAST_EXPAND = 5'(NR_ROUNDS - 2);
    localparam logic [4:0] LAST_ROUND  = 5'(NR_ROUNDS - 1);

    logic [3:0]  state;
    logic [4:0]  counter;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] k;
    logic [63:0] l;
    logic [63:0] key_buf [0:31];

    logic [63:0] l_next;
    logic [63:0] k_next;
    logic [63:0] round_key;
    logic [63:0] xy_mix;
    logic [63:0] y_next;
    logic [63:0] diff;
    logic [63:0] x_next;
    logic        kb_we;
    logic [4:0]  kb_addr;
    logic [63:0] kb_data;

    always_comb begin
        l_next    = (k + {l[7:0], l[63:8]}) ^ {59'd0, counter};
        k_next    = {k[60:0], k[63:61]} ^ l_next;
        round_key = key_buf[counter];
        xy_mix    = y ^ x;
        y_next    = {xy_mix[2:0], xy_mix[63:3]};
        diff      = (x ^ round_key) - y_next;
        x_next    = {diff[55:0], diff[63:56]};
    end

    // Slot 0 takes k0 at the start edge; slot i+1 takes each expanded key.
    always_comb begin
        kb_we   = 1'b0;
        kb_addr = '0;
        kb_data = '0;
        if (state == IDLE && signal_start) begin
            kb_we   = 1'b1;
            kb_addr = '0;
            kb_data = key[63:0];
        end else if (state == EXPAND) begin
            kb_we   = 1'b1;
            kb_addr = counter + 5'd1;
            kb_data = k_next;
        end
    end

    always_ff @(posedge clk) begin
        if (kb_we) begin
            key_buf[kb_addr] <= kb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            finished  <= 1'b0;
            plaintext <= '0;
            x         <= '0;
            y         <= '0;
            k         <= '0;
            l         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (signal_start) begin
                        x       <= ciphertext[127:64];
                        y       <= ciphertext[63:0];
                        l       <= key[127:64];
                        k       <= key[63:0];
                        counter <= '0;
                        state   <= EXPAND;
                    end
                end
                EXPAND: begin
                    l <= l_next;
                    k <= k_next;
                    if (counter == LAST_EXPAND) begin
                        counter <= LAST_ROUND;
                        state   <= DECRYPT;
                    end else begin
                        counter <= counter + 5'd1;
                    end
                end
                DECRYPT: begin
                    x <= x_next;
                    y <= y_next;
                    if (counter == 5'd0) begin
                        plaintext <= {x_next, y_next};
                        finished  <= 1'b1;
                        state     <= DONE;
                    end else begin
                        counter <= counter - 5'd1;
                    end
                end
                DONE: begin
                    finished <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    finished <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign state_response = state;

endmodule

// File: doc/speck_decrypt_core.md
SPECK_DECRYPT_CORE -- requirements
Module: speck_decrypt_core

Interface
REQ-001 SHALL have parameter NR_ROUNDS, default 32, the number of SPECK128/128 rounds; only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port signal_start, input, 1 bit, a request to decrypt; sampled only in IDLE.
REQ-005 SHALL have port key, input, 128 bits, the master key: l0 = key[127:64], k0 = key[63:0].
REQ-006 SHALL have port ciphertext, input, 128 bits: x = [127:64], y = [63:0].
REQ-007 SHALL have port plaintext, output, 128 bits, the decrypted result, same word mapping as ciphertext.
REQ-008 SHALL have port finished, output, 1 bit, a one-cycle completion pulse.
REQ-009 SHALL have port state_response, output, 4 bits, the current FSM state encoding.

Function
REQ-010 SHALL implement the FSM states IDLE=0, EXPAND=1, DECRYPT=2 and DONE=3, with state_response[3:0] equal to the encoding.
REQ-011 In IDLE with signal_start=1 at an edge (E0), SHALL capture key and ciphertext into internal registers, store k0 in round-key slot 0, clear the round counter to 0, and enter EXPAND.
REQ-012 In EXPAND, each edge SHALL compute l[i+1] = (k[i] + ROR64(l[i],8)) XOR i and k[i+1] = ROL64(k[i],3) XOR l[i+1], with i being the counter zero-extended to 64 bits, and store k[i+1] into slot i+1.
REQ-013 EXPAND SHALL run for i = 0..30, which is 31 edges (E1..E31); at i = 30 the FSM SHALL set the counter to 31 and enter DECRYPT.
REQ-014 SHALL hold the 32x64-bit round-key buffer in registers; the buffer is written only in EXPAND and at E0.
REQ-015 In DECRYPT, each edge SHALL apply the inverse round with k = slot[counter]:
- y' = ROR64(y XOR x, 3)
- x' = ROL64((x XOR k) - y', 8)
REQ-016 After each DECRYPT edge the counter SHALL decrement, covering rounds 31 down to 0 over 32 edges (E32..E63).
REQ-017 All additions and subtractions SHALL be modulo 2^64, with carry or borrow discarded.
REQ-018 At E63 (counter = 0), the FSM SHALL:
- load plaintext with {x', y'};
- set finished to 1;
- enter DONE.
REQ-019 In DONE, the next edge (E64) SHALL clear finished and return to IDLE; finished SHALL be high for exactly one cycle.
REQ-020 Latency SHALL be fixed: finished is high during the cycle following E63, 63 edges after the start edge.
REQ-021 signal_start SHALL be ignored in EXPAND, DECRYPT and DONE; changes on key or ciphertext after E0 SHALL NOT affect the result.
REQ-022 If signal_start is held high continuously, a new operation SHALL begin at the first IDLE edge (E65), with a start-to-start spacing of 65 edges.
REQ-023 plaintext SHALL hold its value from E63 until the next E63 or reset; it SHALL NOT change during a later EXPAND or DECRYPT.
REQ-024 The datapath SHALL evaluate one key-schedule step or one inverse round per cycle, with no multi-cycle paths.

Reset
REQ-025 While rst=1, SHALL force the following regardless of clk:
- state = IDLE;
- counter = 0;
- finished = 0;
- plaintext = 0;
- state_response = 0;
- internal x, y, k, l registers = 0.
REQ-026 The round-key buffer need not be cleared by reset; it SHALL be fully rewritten before use.
REQ-027 Reset asserted mid-operation (EXPAND or DECRYPT) SHALL abort it: no finished pulse, and plaintext reads 0.
REQ-028 After rst deasserts, the first signal_start sampled in IDLE SHALL produce a correct, full-latency result.

Verification
REQ-029 Official vector: key=0f0e0d0c0b0a09080706050403020100, ciphertext=a65d98517978326578 60fedf5c570d18 (read as one 128-bit value: a65d9851797832657860fedf5c570d18), one start pulse -> plaintext=6c617669757165207469206564616d20, with finished high exactly one cycle, 63 edges after E0.
REQ-030 state_response trace for the REQ-029 run -> 0 at E0, 1 for E1..E31, 2 for E32..E63, 3 for one cycle, then 0.
REQ-031 Busy rejection: pulse signal_start at E10 and E40, and change key and ciphertext at E5 -> a single finished pulse and the same REQ-029 plaintext.
REQ-032 Continuous start: hold signal_start=1 for two operations with the REQ-029 vector -> finished pulses 65 cycles apart, both with the correct plaintext.
REQ-033 Reset mid-operation: assert rst asynchronously at E45 (in DECRYPT), off the clock edge -> immediately state_response=0, finished=0, plaintext=0; on restart -> the correct REQ-029 result after 63 edges.
REQ-034 Round-trip check: encrypt random key/plaintext pairs with the team's existing round_encrypt/key_schedule chain (key_schedule round_ctr i = i), then feed the ciphertext and key to this block -> plaintext equals the original, for at least 100 vectors.
